tmr_scrub_ctrl: RTL and testbench

Scrubbing controller for the triple-redundant 8-bit counter. Drives the shared count enable of the three counter replicas and votes their outputs bitwise. When exactly one replica disagrees, it stalls counting and reloads that replica with the voted value. It retires replicas that fault repeatedly and halts when no majority exists, and sits between the system `enable` input and the three replicas in the top level.

---
 rtl/tmr_scrub_if.sv | 24 ++
 rtl/tmr_scrub_ctrl.sv | 166 ++++++++++++++++
 tb/tb_tmr_scrub_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/tmr_scrub_if.sv
// Replica-side bus of the TMR scrubbing controller.
// Carries replica outputs in, count enable and load strobes out.
interface tmr_scrub_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] q_a;
    logic [WIDTH-1:0] q_b;
    logic [WIDTH-1:0] q_c;
    logic             cnt_en;
    logic             load_a;
    logic             load_b;
    logic             load_c;
    logic [WIDTH-1:0] load_val;

    modport master (
        input  q_a, q_b, q_c,
        output cnt_en, load_a, load_b, load_c, load_val
    );

    modport slave (
        output q_a, q_b, q_c,
        input  cnt_en, load_a, load_b, load_c, load_val
    );
endinterface

// File: rtl/tmr_scrub_ctrl.sv
// Scrubbing controller for a triple-redundant counter.
// Votes the replicas, reloads a single faulty one, retires repeat offenders.
module tmr_scrub_ctrl #(
    parameter int WIDTH    = 8,
    parameter int PERSIST  = 3,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    tmr_scrub_if.master         rep,
    output logic [WIDTH-1:0]    q_out,
    output logic                err,
    output logic [ERRCNT_W-1:0] err_cnt,
    output logic [2:0]          fail_mask,
    output logic                uncorrectable
);

    localparam int FCW = $clog2(PERSIST + 1);

    typedef enum logic [1:0] {
        RUN,
        RESYNC,
        HALT
    } state_e;

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       q_out_q, q_out_d;
    logic [WIDTH-1:0]       load_val_q, load_val_d;
    logic [1:0]             idx_q, idx_d;
    logic                   err_q, err_d;
    logic [ERRCNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic [2:0][FCW-1:0]    fcnt_q, fcnt_d;
    logic [2:0]             fail_mask_q, fail_mask_d;
    logic                   unc_q, unc_d;

    logic [WIDTH-1:0]       maj;
    logic [WIDTH-1:0]       vote;
    logic [2:0]             mis;
    logic                   nomaj;
    logic                   single;
    logic [1:0]             mis_idx;
    logic                   cnt_en_c;
    logic [2:0]             load_c;

    assign maj = (rep.q_a & rep.q_b) | (rep.q_a & rep.q_c) | (rep.q_b & rep.q_c);

    // A retired replica takes no part in the vote and is never reloaded.
    always_comb begin
        vote  = maj;
        mis   = 3'b000;
        nomaj = 1'b0;
        case (fail_mask_q)
            3'b000: begin
                vote  = maj;
                mis   = {rep.q_c != maj, rep.q_b != maj, rep.q_a != maj};
                nomaj = (rep.q_a != rep.q_b) && (rep.q_a != rep.q_c) &&
                        (rep.q_b != rep.q_c);
            end
            3'b001: begin
                vote  = rep.q_b;
                nomaj = rep.q_b != rep.q_c;
            end
            3'b010: begin
                vote  = rep.q_a;
                nomaj = rep.q_a != rep.q_c;
            end
            3'b100: begin
                vote  = rep.q_a;
                nomaj = rep.q_a != rep.q_b;
            end
            default: begin
                vote  = rep.q_a;
                nomaj = 1'b0;
            end
        endcase
    end

    assign single  = !nomaj && (mis != 3'b000);
    assign mis_idx = mis[0] ? 2'd0 : (mis[1] ? 2'd1 : 2'd2);

    always_comb begin
        state_d     = state_q;
        q_out_d     = q_out_q;
        load_val_d  = load_val_q;
        idx_d       = idx_q;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;
        fcnt_d      = fcnt_q;
        fail_mask_d = fail_mask_q;
        unc_d       = unc_q;
        cnt_en_c    = 1'b0;
        load_c      = 3'b000;
        case (state_q)
            RUN: begin
                if (nomaj) begin
                    state_d = HALT;
                    unc_d   = 1'b1;
                end else if (single) begin
                    state_d    = RESYNC;
                    q_out_d    = vote;
                    load_val_d = vote;
                    idx_d      = mis_idx;
                    err_d      = 1'b1;
                    if (err_cnt_q != {ERRCNT_W{1'b1}})
                        err_cnt_d = err_cnt_q + 1'b1;
                    if (fcnt_q[mis_idx] != FCW'(PERSIST))
                        fcnt_d[mis_idx] = fcnt_q[mis_idx] + 1'b1;
                end else begin
                    cnt_en_c = enable;
                    q_out_d  = vote;
                end
            end
            RESYNC: begin
                state_d        = RUN;
                load_c[idx_q]  = 1'b1;
                if (fcnt_q[idx_q] == FCW'(PERSIST))
                    fail_mask_d[idx_q] = 1'b1;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            q_out_q     <= '0;
            load_val_q  <= '0;
            idx_q       <= 2'd0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            fcnt_q      <= '0;
            fail_mask_q <= 3'b000;
            unc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_out_q     <= q_out_d;
            load_val_q  <= load_val_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            fcnt_q      <= fcnt_d;
            fail_mask_q <= fail_mask_d;
            unc_q       <= unc_d;
        end
    end

    // Reset overrides the stall/load logic so no strobe escapes during rst.
    assign rep.cnt_en   = cnt_en_c & ~rst;
    assign rep.load_a   = load_c[0] & ~rst;
    assign rep.load_b   = load_c[1] & ~rst;
    assign rep.load_c   = load_c[2] & ~rst;
    assign rep.load_val = load_val_q;

    assign q_out         = q_out_q;
    assign err           = err_q;
    assign err_cnt       = err_cnt_q;
    assign fail_mask     = fail_mask_q;
    assign uncorrectable = unc_q;

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Directed bench for tmr_scrub_ctrl: vector table plus a
// saturation sequence on a narrow error counter instance.
module tb_tmr_scrub_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, enable;
    logic [7:0] q_out;
    logic       err;
    logic [7:0] err_cnt;
    logic [2:0] fail_mask;
    logic       unc;

    logic       rst2, enable2;
    logic [7:0] q_out2;
    logic       err2;
    logic [1:0] err_cnt2;
    logic [2:0] fail_mask2;
    logic       unc2;

    tmr_scrub_if #(.WIDTH(8)) bus ();
    tmr_scrub_if #(.WIDTH(8)) bus2 ();

    tmr_scrub_ctrl #(.WIDTH(8), .PERSIST(3), .ERRCNT_W(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .rep(bus),
        .q_out(q_out), .err(err), .err_cnt(err_cnt),
        .fail_mask(fail_mask), .uncorrectable(unc)
    );

    tmr_scrub_ctrl #(.WIDTH(8), .PERSIST(3), .ERRCNT_W(2)) dut2 (
        .clk(clk), .rst(rst2), .enable(enable2), .rep(bus2),
        .q_out(q_out2), .err(err2), .err_cnt(err_cnt2),
        .fail_mask(fail_mask2), .uncorrectable(unc2)
    );

    typedef struct {
        logic       rst, en;
        logic [7:0] a, b, c;
        logic       cen;
        logic [2:0] ld;
        logic [7:0] lv, qo;
        logic       err;
        logic [7:0] ec;
        logic [2:0] fm;
        logic       unc;
    } vec_t;

    vec_t vq[$];
    int n_cmp = 0;
    int n_fail = 0;

    task automatic add(input logic r, input logic e,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic cen,
                       input logic [2:0] ld, input logic [7:0] lv,
                       input logic [7:0] qo, input logic er,
                       input logic [7:0] ec, input logic [2:0] fm,
                       input logic un);
        vec_t v;
        v.rst = r; v.en = e; v.a = a; v.b = b; v.c = c;
        v.cen = cen; v.ld = ld; v.lv = lv; v.qo = qo;
        v.err = er; v.ec = ec; v.fm = fm; v.unc = un;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0h expected %0h",
                     name, idx, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0;
        bus.q_a = '0; bus.q_b = '0; bus.q_c = '0;
        rst2 = 1'b1; enable2 = 1'b0;
        bus2.q_a = '0; bus2.q_b = '0; bus2.q_c = '0;

        add(1,1,8'h00,8'h00,8'h00, 0,3'b000,8'h00,8'h00,0,0,3'b000,0);
        for (int i = 0; i < 10; i++)
            add(0,1,8'(i),8'(i),8'(i), 1,3'b000,8'h00,8'(i),0,0,3'b000,0);
        add(0,1,8'h05,8'h85,8'h05, 0,3'b000,8'h05,8'h05,1,1,3'b000,0);
        add(0,1,8'h05,8'h85,8'h05, 0,3'b010,8'h05,8'h05,0,1,3'b000,0);
        add(0,1,8'h05,8'h05,8'h05, 1,3'b000,8'h05,8'h05,0,1,3'b000,0);
        for (int j = 1; j <= 3; j++) begin
            logic [2:0] fm;
            fm = (j == 3) ? 3'b100 : 3'b000;
            add(0,1,8'h05,8'h05,8'h07, 0,3'b000,8'h05,8'h05,1,8'(1+j),3'b000,0);
            add(0,1,8'h05,8'h05,8'h07, 0,3'b100,8'h05,8'h05,0,8'(1+j),fm,0);
            add(0,1,8'h05,8'h05,8'h05, 1,3'b000,8'h05,8'h05,0,8'(1+j),fm,0);
        end
        add(0,1,8'h06,8'h06,8'hFF, 1,3'b000,8'h05,8'h06,0,4,3'b100,0);
        add(0,0,8'h07,8'h07,8'h00, 0,3'b000,8'h05,8'h07,0,4,3'b100,0);
        add(0,1,8'h01,8'h02,8'hFF, 0,3'b000,8'h05,8'h07,0,4,3'b100,1);
        add(0,1,8'h07,8'h07,8'h07, 0,3'b000,8'h05,8'h07,0,4,3'b100,1);
        add(1,1,8'h00,8'h00,8'h00, 0,3'b000,8'h00,8'h00,0,0,3'b000,0);
        add(0,1,8'h09,8'h09,8'h09, 1,3'b000,8'h00,8'h09,0,0,3'b000,0);
        add(0,1,8'h01,8'h02,8'h03, 0,3'b000,8'h00,8'h09,0,0,3'b000,1);
        add(0,1,8'h04,8'h04,8'h04, 0,3'b000,8'h00,8'h09,0,0,3'b000,1);
        add(0,1,8'h04,8'h04,8'h04, 0,3'b000,8'h00,8'h09,0,0,3'b000,1);
        add(1,0,8'h04,8'h04,8'h04, 0,3'b000,8'h00,8'h00,0,0,3'b000,0);
        add(0,1,8'h10,8'h10,8'h10, 1,3'b000,8'h00,8'h10,0,0,3'b000,0);
        add(0,1,8'h11,8'h10,8'h10, 0,3'b000,8'h10,8'h10,1,1,3'b000,0);
        add(1,1,8'h11,8'h10,8'h10, 0,3'b000,8'h00,8'h00,0,0,3'b000,0);
        add(0,1,8'h10,8'h10,8'h10, 1,3'b000,8'h00,8'h10,0,0,3'b000,0);

        @(posedge clk); #1;
        for (int k = 0; k < vq.size(); k++) begin
            rst = vq[k].rst; enable = vq[k].en;
            bus.q_a = vq[k].a; bus.q_b = vq[k].b; bus.q_c = vq[k].c;
            #1;
            check("cnt_en", k, 32'(bus.cnt_en), 32'(vq[k].cen));
            check("load", k, 32'({bus.load_c, bus.load_b, bus.load_a}),
                  32'(vq[k].ld));
            @(posedge clk); #1;
            check("load_val", k, 32'(bus.load_val), 32'(vq[k].lv));
            check("q_out", k, 32'(q_out), 32'(vq[k].qo));
            check("err", k, 32'(err), 32'(vq[k].err));
            check("err_cnt", k, 32'(err_cnt), 32'(vq[k].ec));
            check("fail_mask", k, 32'(fail_mask), 32'(vq[k].fm));
            check("uncorrectable", k, 32'(unc), 32'(vq[k].unc));
        end

        rst2 = 1'b1; enable2 = 1'b1;
        @(posedge clk); #1;
        rst2 = 1'b0;
        bus2.q_a = 8'h20; bus2.q_b = 8'h20; bus2.q_c = 8'h20;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            int r;
            r = k % 3;
            bus2.q_a = (r == 0) ? 8'h21 : 8'h20;
            bus2.q_b = (r == 1) ? 8'h21 : 8'h20;
            bus2.q_c = (r == 2) ? 8'h21 : 8'h20;
            #1;
            check("sat_cnt_en", 100 + k, 32'(bus2.cnt_en), 32'd0);
            @(posedge clk); #1;
            check("sat_err", 100 + k, 32'(err2), 32'd1);
            check("sat_err_cnt", 100 + k, 32'(err_cnt2),
                  32'((k + 1 > 3) ? 3 : k + 1));
            check("sat_load", 100 + k,
                  32'({bus2.load_c, bus2.load_b, bus2.load_a}),
                  32'(1 << r));
            check("sat_load_val", 100 + k, 32'(bus2.load_val), 32'h20);
            @(posedge clk); #1;
            bus2.q_a = 8'h20; bus2.q_b = 8'h20; bus2.q_c = 8'h20;
            @(posedge clk); #1;
        end
        check("sat_final_cnt", 200, 32'(err_cnt2), 32'd3);
        check("sat_fail_mask", 200, 32'(fail_mask2), 32'd0);
        check("sat_unc", 200, 32'(unc2), 32'd0);
        check("sat_q_out", 200, 32'(q_out2), 32'h20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
